mem_sync_clr: RTL and testbench
===============================

Name: mem_sync_clr

Overview:
- Parametrised single-port synchronous RAM with registered read data and a req/ready/rvalid handshake.
- Hardware clear engine zeroes every location after reset or on a soft-clear request.
- Out-of-range address flagging.
- Used as the general-purpose scratch/config storage block in the datapath, replacing ad-hoc asynchronous-read memories.

Parameters:
- ADDR_WIDTH, 3, address bus width.
- DATA_WIDTH, 4, word width in bits.
- DEPTH, 8, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  soft clear request, level-sampled.
- req  input  1  access request.
- wr  input  1  1 = write, 0 = read; qualified by req.
- addr  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- ready  output  1  block can accept a request this cycle.
- rvalid  output  1  one-cycle pulse: data_out valid for a read.
- data_out  output  DATA_WIDTH  registered read data.
- addr_err  output  1  one-cycle pulse: accepted access had addr >= DEPTH.
- init_done  output  1  high once the clear sweep has completed.
- parity_err  output  1  read parity mismatch (optional feature, else tied 0).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: ready=0, rvalid=0, data_out=0, addr_err=0, init_done=0, parity_err=0, state=INIT, clear counter=0.
- Reset mid-operation: all state and outputs go to reset values immediately. Any in-flight read is dropped (no rvalid). The sweep restarts from location 0 after rst_n rises.
- States: INIT, IDLE.
- INIT:
  - Writes 0 to location cnt each cycle; cnt increments 0..DEPTH-1.
  - On the cycle cnt==DEPTH-1 is written, go to IDLE and set init_done=1.
  - Sweep takes exactly DEPTH cycles after the first clk edge with rst_n high.
  - ready=0; req is ignored.
  - clr is ignored in INIT; the sweep is not restarted.
- IDLE:
  - ready = !clr (combinational on clr).
  - clr=1 in IDLE: next state INIT, init_done cleared next edge, counter reset to 0. Any req in that cycle is not accepted.
- Accepted transfer: req && ready at a rising edge.
- Write:
  - If addr < DEPTH, mem[addr] <= data_in at that edge.
  - If addr >= DEPTH, memory is unchanged and addr_err pulses the next cycle.
  - No rvalid for writes.
- Read:
  - Latency 1. Next cycle rvalid=1 and data_out=mem[addr].
  - addr >= DEPTH returns data_out=0 with rvalid=1 and addr_err=1.
- data_out holds its last read value when rvalid=0. It is cleared only by reset, not by clr.
- Back-to-back: one accepted transfer per cycle, no bubbles.
- A read one cycle after a write to the same address returns the new data.
- Read and write never coincide: single port.

Optional Feature:
- Macro: MEM_SYNC_PARITY_EN.
- Defined:
  - Each word stores DATA_WIDTH+1 bits; the extra bit is even parity of the data.
  - The clear sweep writes parity 0.
  - On a read of an in-range address, parity_err pulses alongside rvalid if recomputed parity differs from the stored bit.
  - Out-of-range reads never flag parity_err.
- Undefined: storage is DATA_WIDTH bits and parity_err is tied 0. The port list is identical either way.

Decomposition:
- Package mem_sync_pkg:
  - State encoding localparams ST_INIT/ST_IDLE.
  - Function for clear-counter width ($clog2 of DEPTH, minimum 1).
  - Even-parity function.
- Sub-module mem_sync_array:
  - Owns the storage array.
  - One synchronous write port, one synchronous registered read port, parametrised word width.
  - The top holds the FSM, clear counter, handshake and error logic.

Test Plan:
- Release rst_n and hold req=1 → ready=0 for exactly 8 cycles, then init_done=1 and ready=1. A read of addr 5 returns rvalid=1, data_out=4'b0000.
- Write addr 3 = 4'b1010, then read addr 3 on the next cycle → next cycle rvalid=1, data_out=4'b1010, addr_err=0.
- With parameters ADDR_WIDTH=3, DEPTH=6: write addr 7 = 4'b1111 → addr_err pulse, no rvalid. Read addr 7 → rvalid=1, data_out=0, addr_err=1. Read addr 3 still shows prior contents.
- After filling all words with 4'b0110, pulse clr with req=1 the same cycle → request not accepted, ready=0 for 8 cycles. Reads of every address then return 0.
- Assert rst_n=0 mid read-burst → outputs zero asynchronously and no rvalid for the dropped read. The sweep repeats and init_done rises 8 cycles after release.
- With MEM_SYNC_PARITY_EN: write addr 2 = 4'b0111, force-flip the stored parity bit, read addr 2 → rvalid=1, data_out=4'b0111, parity_err=1.

Source files
------------

// File: rtl/mem_sync_pkg.sv
// mem_sync_pkg: shared state encoding and helper functions for mem_sync_clr.
package mem_sync_pkg;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_IDLE = 1'b1;

    typedef enum logic {
        INIT = ST_INIT,
        IDLE = ST_IDLE
    } state_e;

    // Clear-counter width: enough bits to count 0..depth-1, never less than 1.
    function automatic int clr_cnt_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_sync_array.sv
// mem_sync_array: storage with one synchronous write port and one
// registered read port. The read register can be forced to zero for
// reads the caller knows fall outside the implemented range.
module mem_sync_array #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int WORD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rzero_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Write port; caller guarantees waddr_i < DEPTH whenever we_i is set.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read; holds its value between reads, zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (re_i)  rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sync_clr.sv
// mem_sync_clr: single-port synchronous RAM with a hardware clear sweep
// after reset or soft clear, req/ready/rvalid handshake and out-of-range
// flagging. Define MEM_SYNC_PARITY_EN to store an even-parity bit per word
// and report read parity mismatches on parity_err.
module mem_sync_clr
    import mem_sync_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  addr_err,
    output logic                  init_done,
    output logic                  parity_err
);

    localparam int CW = clr_cnt_width(DEPTH);
`ifdef MEM_SYNC_PARITY_EN
    localparam int WW = DATA_WIDTH + 1;
`else
    localparam int WW = DATA_WIDTH;
`endif
    localparam logic [CW-1:0]       LAST    = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic            aerr_q, aerr_d;

    logic                  in_range, acc, rd_acc, we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [WW-1:0]         wdata, rdata;

    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign ready    = (state_q == IDLE) && !clr;
    assign acc      = req && ready;
    assign rd_acc   = acc && !wr;

    // Write port is owned by the sweep in INIT, by accepted writes in IDLE.
    always_comb begin
        we    = 1'b0;
        waddr = addr;
        wdata = '0;
        if (state_q == INIT) begin
            we    = 1'b1;
            waddr = ADDR_WIDTH'(cnt_q);
        end else if (acc && wr && in_range) begin
            we = 1'b1;
`ifdef MEM_SYNC_PARITY_EN
            wdata = {even_parity(64'(data_in)), data_in};
`else
            wdata = data_in;
`endif
        end
    end

    // Next state: sweep DEPTH words in INIT, re-enter INIT on clr from IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = rd_acc;
        aerr_d   = acc && !in_range;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, counter and one-cycle response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    mem_sync_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (rd_acc),
        .rzero_i (!in_range),
        .raddr_i (addr),
        .rdata_o (rdata)
    );

    assign rvalid    = rvalid_q;
    assign addr_err  = aerr_q;
    assign init_done = (state_q == IDLE);
    assign data_out  = rdata[DATA_WIDTH-1:0];

`ifdef MEM_SYNC_PARITY_EN
    logic rd_inr_q;

    // Remember whether the in-flight read hit a real word; only those check parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_inr_q <= 1'b0;
        else if (rd_acc) rd_inr_q <= in_range;
    end

    assign parity_err = rvalid_q && rd_inr_q &&
                        (even_parity(64'(rdata[DATA_WIDTH-1:0])) != rdata[DATA_WIDTH]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sync_clr.sv
// tb_mem_sync_clr: directed and randomized checks of mem_sync_clr against a
// behavioural model (word array + remaining-sweep-cycles counter).
module tb_mem_sync_clr;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 6;

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0, req = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic          ready, rvalid, addr_err, init_done, parity_err;
    logic [DW-1:0] data_out;

    mem_sync_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .wr(wr), .addr(addr),
        .data_in(data_in), .ready(ready), .rvalid(rvalid), .data_out(data_out),
        .addr_err(addr_err), .init_done(init_done), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    int mem_m [8];
    int busy;        // sweep cycles still to run; 0 means accepting requests
    int exp_rv, exp_ae, exp_do;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = DEPTH;
        foreach (mem_m[i]) mem_m[i] = 0;
        exp_rv = 0; exp_ae = 0; exp_do = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".rvalid"},     32'(rvalid),     32'(exp_rv));
        chk({tag, ".data_out"},   32'(data_out),   32'(exp_do));
        chk({tag, ".addr_err"},   32'(addr_err),   32'(exp_ae));
        chk({tag, ".init_done"},  32'(init_done),  32'(busy == 0));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(0));
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic step(input string tag, input bit r, input bit w, input int a, input int d, input bit c);
        @(negedge clk);
        req = r; wr = w; addr = a[AW-1:0]; data_in = d[DW-1:0]; clr = c;
        #1 chk({tag, ".ready"}, 32'(ready), 32'(busy == 0 && !c));
        @(posedge clk);
        exp_rv = 0; exp_ae = 0;
        if (busy > 0) begin
            busy--;
        end else if (c) begin
            busy = DEPTH;
            foreach (mem_m[i]) mem_m[i] = 0;
        end else if (r) begin
            exp_ae = (a >= DEPTH);
            if (w) begin
                if (a < DEPTH) mem_m[a] = d;
            end else begin
                exp_rv = 1;
                exp_do = (a < DEPTH) ? mem_m[a] : 0;
            end
        end
        #1 check_outs(tag);
    endtask

    // Reset asserted while a read is being presented: outputs clear at once, read dropped.
    task automatic reset_mid();
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 3'd1; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.ready",     32'(ready),     32'(0));
        chk("rst.rvalid",    32'(rvalid),    32'(0));
        chk("rst.data_out",  32'(data_out),  32'(0));
        chk("rst.addr_err",  32'(addr_err),  32'(0));
        chk("rst.init_done", 32'(init_done), 32'(0));
        model_reset();
        @(posedge clk);
        #1 check_outs("rst_hold");
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        chk("por.ready",      32'(ready),      32'(0));
        chk("por.rvalid",     32'(rvalid),     32'(0));
        chk("por.data_out",   32'(data_out),   32'(0));
        chk("por.addr_err",   32'(addr_err),   32'(0));
        chk("por.init_done",  32'(init_done),  32'(0));
        chk("por.parity_err", 32'(parity_err), 32'(0));
        #13 rst_n = 1'b1;

        // Sweep: ready low for DEPTH cycles even with req held
        for (int i = 0; i < DEPTH; i++) step("sweep", 1, 0, 5, 0, 0);
        chk("sweep.done", 32'(init_done), 32'(1));
        step("rd5", 1, 0, 5, 0, 0);
        chk("rd5.zero", 32'(data_out), 32'(0));

        // Write then immediate read-back
        step("wr3", 1, 1, 3, 4'hA, 0);
        step("rd3", 1, 0, 3, 0, 0);
        chk("rd3.data", 32'(data_out), 32'hA);

        // Out-of-range write and read
        step("wr7", 1, 1, 7, 4'hF, 0);
        step("rd7", 1, 0, 7, 0, 0);
        step("rd3b", 1, 0, 3, 0, 0);
        step("rd6", 1, 0, 6, 0, 0);

        // Fill, then soft clear with a simultaneous request
        for (int a = 0; a < DEPTH; a++) step("fill", 1, 1, a, 4'h6, 0);
        step("rd_fill", 1, 0, 4, 0, 0);
        step("clr", 1, 1, 0, 4'hF, 1);
        for (int i = 0; i < DEPTH; i++) step("clr_sweep", 1, 0, 2, 0, 1);
        for (int a = 0; a < 8; a++) step("rd_clr", 1, 0, a, 0, 0);
        step("rd_hold", 0, 0, 0, 0, 0);

        // Reset in the middle of a read burst
        step("wr1", 1, 1, 1, 4'h9, 0);
        step("burst", 1, 0, 1, 0, 0);
        step("burst", 1, 0, 2, 0, 0);
        reset_mid();
        for (int i = 0; i < DEPTH; i++) step("resweep", 1, 0, 1, 0, 0);
        step("rd1_after_rst", 1, 0, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_mid();
            end else begin
                step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
